// File: rtl/i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// i2s_tx_serializer
//
// I2S transmitter and bit/word clock master for the DAC side of the audio
// path. The system clock is divided down to bclk. l_r_clk is the word
// select, and it also feeds the filter chain as its sample-edge input.
// Filtered samples arrive as one-cycle strobes with no backpressure. They
// are parked in per-channel holding registers. Each sample is then shifted
// out MSB-first, one bclk period after the l_r_clk transition (standard I2S
// one-bit delay).
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   sample_in    in   signed sample to transmit (WORD_BITS)
//   sample_valid in   one-cycle strobe qualifying sample_in/sample_chan
//   sample_chan  in   0 = left, 1 = right
//   bclk         out  serial bit clock
//   l_r_clk      out  word select, 0 = left slot, 1 = right slot
//   sdata        out  serial data, changes with the bclk falling edge
//   slot_start   out  one-cycle pulse when a slot's shift register loads
//   underrun     out  one-cycle pulse when a slot loads without a fresh sample
//
// Build option:
//   I2S_TX_UNDERRUN_ZERO_EN  when defined, an underrun slot sends all zeros.
//                            Otherwise the last held sample is repeated.
// ---------------------------------------------------------------------------
module i2s_tx_serializer #(
  parameter int BCLK_DIV  = 4,
  parameter int WORD_BITS = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WORD_BITS-1:0] sample_in,
  input  logic                        sample_valid,
  input  logic                        sample_chan,
  output logic                        bclk,
  output logic                        l_r_clk,
  output logic                        sdata,
  output logic                        slot_start,
  output logic                        underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int IDX_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  typedef enum logic {
    SLOT_LEFT  = 1'b0,
    SLOT_RIGHT = 1'b1
  } slot_e;

  logic [DIV_W-1:0]     divCnt_q, divCnt_d;
  logic                 bclk_q, bclk_d;
  logic [IDX_W-1:0]     bitIdx_q, bitIdx_d;
  slot_e                slot_q, slot_d;
  logic [WORD_BITS-1:0] shiftReg_q, shiftReg_d;
  logic                 sdata_q, sdata_d;
  logic                 slotStart_q, slotStart_d;
  logic                 underrun_q, underrun_d;
  logic [WORD_BITS-1:0] holdL_q, holdL_d, holdR_q, holdR_d;
  logic                 freshL_q, freshL_d, freshR_q, freshR_d;

  logic                 divDone;
  logic                 bitTick;
  logic                 slotWrap;
  logic                 nextRight;
  logic [WORD_BITS-1:0] loadHold;
  logic                 loadFresh;

  // A bit tick is the bclk 1->0 toggle. Every slot boundary and every data
  // change lines up with this edge.
  assign divDone   = (divCnt_q == DIV_W'(BCLK_DIV - 1));
  assign bitTick   = divDone & bclk_q;
  assign slotWrap  = (bitIdx_q == IDX_W'(SLOT_BITS - 1));
  assign nextRight = (slot_q == SLOT_LEFT);
  assign loadHold  = nextRight ? holdR_q : holdL_q;
  assign loadFresh = nextRight ? freshR_q : freshL_q;

  // State register. Reset clears everything at once, so a mid-slot reset
  // aborts the slot and restarts in the left slot at period 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      divCnt_q    <= '0;
      bclk_q      <= 1'b0;
      bitIdx_q    <= '0;
      slot_q      <= SLOT_LEFT;
      shiftReg_q  <= '0;
      sdata_q     <= 1'b0;
      slotStart_q <= 1'b0;
      underrun_q  <= 1'b0;
      holdL_q     <= '0;
      holdR_q     <= '0;
      freshL_q    <= 1'b0;
      freshR_q    <= 1'b0;
    end else begin
      divCnt_q    <= divCnt_d;
      bclk_q      <= bclk_d;
      bitIdx_q    <= bitIdx_d;
      slot_q      <= slot_d;
      shiftReg_q  <= shiftReg_d;
      sdata_q     <= sdata_d;
      slotStart_q <= slotStart_d;
      underrun_q  <= underrun_d;
      holdL_q     <= holdL_d;
      holdR_q     <= holdR_d;
      freshL_q    <= freshL_d;
      freshR_q    <= freshR_d;
    end
  end

  // Next-state logic: divider, slot sequencing, shift-out and sample capture.
  always_comb begin
    divCnt_d    = divDone ? '0 : divCnt_q + DIV_W'(1);
    bclk_d      = divDone ? ~bclk_q : bclk_q;
    bitIdx_d    = bitIdx_q;
    slot_d      = slot_q;
    shiftReg_d  = shiftReg_q;
    sdata_d     = sdata_q;
    slotStart_d = 1'b0;
    underrun_d  = 1'b0;
    holdL_d     = holdL_q;
    holdR_d     = holdR_q;
    freshL_d    = freshL_q;
    freshR_d    = freshR_q;

    if (bitTick) begin
      if (slotWrap) begin
        // Slot boundary: switch channel and load that channel's held word.
        // Period 0 carries the I2S one-bit delay, so sdata is low here.
        bitIdx_d    = '0;
        slot_d      = nextRight ? SLOT_RIGHT : SLOT_LEFT;
        slotStart_d = 1'b1;
        underrun_d  = ~loadFresh;
        sdata_d     = 1'b0;
`ifdef I2S_TX_UNDERRUN_ZERO_EN
        shiftReg_d  = loadFresh ? loadHold : '0;
`else
        shiftReg_d  = loadHold;
`endif
        if (nextRight) begin
          freshR_d = 1'b0;
        end else begin
          freshL_d = 1'b0;
        end
      end else begin
        // Periods 1..WORD_BITS carry the word MSB-first. The rest pad with 0.
        bitIdx_d = bitIdx_q + IDX_W'(1);
        if (bitIdx_q < IDX_W'(WORD_BITS)) begin
          sdata_d    = shiftReg_q[WORD_BITS-1];
          shiftReg_d = {shiftReg_q[WORD_BITS-2:0], 1'b0};
        end else begin
          sdata_d = 1'b0;
        end
      end
    end

    // Capture comes after the load, so a write that coincides with a load of
    // the same channel keeps its fresh flag for the following frame. The
    // load itself already used the pre-write hold value.
    if (sample_valid) begin
      if (sample_chan) begin
        holdR_d  = sample_in;
        freshR_d = 1'b1;
      end else begin
        holdL_d  = sample_in;
        freshL_d = 1'b1;
      end
    end
  end

  assign bclk       = bclk_q;
  assign l_r_clk    = (slot_q == SLOT_RIGHT);
  assign sdata      = sdata_q;
  assign slot_start = slotStart_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// ---------------------------------------------------------------------------
// tb_i2s_tx_serializer
//
// Directed bench for i2s_tx_serializer with default parameters. With these
// defaults a slot is 256 clk cycles. Slot j (j >= 1) loads on clk edge 256*j
// after reset release: odd j are right slots and even j are left slots. Slot
// 0 is the left slot that starts at reset and is never loaded.
// ---------------------------------------------------------------------------
module tb_i2s_tx_serializer;

  logic               clk;
  logic               reset;
  logic signed [15:0] sampleIn;
  logic               sampleValid;
  logic               sampleChan;
  logic               bclk;
  logic               lrClk;
  logic               sdata;
  logic               slotStart;
  logic               underrun;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [15:0] rightAfterUnderrun;

  i2s_tx_serializer #(
    .BCLK_DIV (4),
    .WORD_BITS(16),
    .SLOT_BITS(32)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_in   (sampleIn),
    .sample_valid(sampleValid),
    .sample_chan (sampleChan),
    .bclk        (bclk),
    .l_r_clk     (lrClk),
    .sdata       (sdata),
    .slot_start  (slotStart),
    .underrun    (underrun)
  );

  // 10 ns system clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, and on mismatch count and report it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to 1 ns after clk edge number c (counted from reset release)
  task automatic stepTo(input int c);
    while (cyc < c) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  // One-cycle sample strobe, captured on the next clk edge
  task automatic applyStimulus(input logic chan, input logic [15:0] value);
    sampleChan  = chan;
    sampleIn    = value;
    sampleValid = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    sampleValid = 1'b0;
  endtask

  // Walk one slot starting at edge s: check the load pulses when asked, then
  // read sdata and l_r_clk in every bclk period while bclk is high
  task automatic checkSlot(input int s, input logic [15:0] word,
                           input logic expUnderrun, input logic expLr,
                           input logic withLoad);
    logic expBit;
    if (withLoad) begin
      stepTo(s);
      checkOutput($sformatf("slot_start@%0d", s), 32'(slotStart), 32'd1);
      checkOutput($sformatf("underrun@%0d", s), 32'(underrun), 32'(expUnderrun));
      checkOutput($sformatf("l_r_clk@%0d", s), 32'(lrClk), 32'(expLr));
      stepTo(s + 1);
      checkOutput($sformatf("slot_start_end@%0d", s + 1), 32'(slotStart), 32'd0);
      checkOutput($sformatf("underrun_end@%0d", s + 1), 32'(underrun), 32'd0);
    end
    for (int k = 0; k < 32; k++) begin
      expBit = (k >= 1 && k <= 16) ? word[16-k] : 1'b0;
      stepTo(s + 8 * k + 5);
      checkOutput($sformatf("sdata_s%0d_p%0d", s, k), 32'(sdata), 32'(expBit));
      checkOutput($sformatf("l_r_clk_s%0d_p%0d", s, k), 32'(lrClk), 32'(expLr));
    end
  endtask

  // Directed sequence
  initial begin
`ifdef I2S_TX_UNDERRUN_ZERO_EN
    rightAfterUnderrun = 16'h0000;
`else
    rightAfterUnderrun = 16'h0F0F;
`endif
    reset       = 1'b0;
    sampleIn    = '0;
    sampleValid = 1'b0;
    sampleChan  = 1'b0;

    // Outputs held low while reset is asserted
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_bclk", 32'(bclk), 32'd0);
    checkOutput("rst_lrclk", 32'(lrClk), 32'd0);
    checkOutput("rst_sdata", 32'(sdata), 32'd0);
    checkOutput("rst_slot_start", 32'(slotStart), 32'd0);
    checkOutput("rst_underrun", 32'(underrun), 32'd0);

    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;

    // bclk: low for 4 cycles, high for 4, first fall on edge 8
    stepTo(3);  checkOutput("bclk@3", 32'(bclk), 32'd0);
    stepTo(4);  checkOutput("bclk@4", 32'(bclk), 32'd1);
    stepTo(7);  checkOutput("bclk@7", 32'(bclk), 32'd1);
    stepTo(8);  checkOutput("bclk@8", 32'(bclk), 32'd0);
    stepTo(12); checkOutput("bclk@12", 32'(bclk), 32'd1);

    // Load both channels before the first slot boundary
    stepTo(19);
    applyStimulus(1'b0, 16'hA5C3);
    applyStimulus(1'b1, 16'h0F0F);

    stepTo(250);
    checkOutput("sdata_idle@250", 32'(sdata), 32'd0);
    stepTo(255);
    checkOutput("l_r_clk@255", 32'(lrClk), 32'd0);
    checkOutput("slot_start@255", 32'(slotStart), 32'd0);

    // Right then left, both fresh
    checkSlot(256, 16'h0F0F, 1'b0, 1'b1, 1'b1);
    checkSlot(512, 16'hA5C3, 1'b0, 1'b0, 1'b1);

    // Next frame supplies left only, so the right slot underruns
    applyStimulus(1'b0, 16'h8000);
    checkSlot(768, rightAfterUnderrun, 1'b1, 1'b1, 1'b1);
    checkSlot(1024, 16'h8000, 1'b0, 1'b0, 1'b1);

    applyStimulus(1'b1, 16'h7FFE);
    applyStimulus(1'b0, 16'hFFFF);
    checkSlot(1280, 16'h7FFE, 1'b0, 1'b1, 1'b1);

    // Left write lands on the same edge as the left load
    applyStimulus(1'b1, 16'h5A5A);
    stepTo(1535);
    applyStimulus(1'b0, 16'h1234);
    checkSlot(1536, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    checkSlot(1792, 16'h5A5A, 1'b0, 1'b1, 1'b1);
    checkSlot(2048, 16'h1234, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a right slot while bclk, l_r_clk, sdata are high
    applyStimulus(1'b1, 16'h1111);
    stepTo(2304);
    checkOutput("slot_start@2304", 32'(slotStart), 32'd1);
    checkOutput("underrun@2304", 32'(underrun), 32'd0);
    stepTo(2304 + 37);
    checkOutput("pre_rst_bclk", 32'(bclk), 32'd1);
    checkOutput("pre_rst_lrclk", 32'(lrClk), 32'd1);
    checkOutput("pre_rst_sdata", 32'(sdata), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_rst_bclk", 32'(bclk), 32'd0);
    checkOutput("async_rst_lrclk", 32'(lrClk), 32'd0);
    checkOutput("async_rst_sdata", 32'(sdata), 32'd0);
    checkOutput("async_rst_slot_start", 32'(slotStart), 32'd0);
    checkOutput("async_rst_underrun", 32'(underrun), 32'd0);

    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc   = 0;

    // Restart in the left slot, and the held samples are gone
    stepTo(3); checkOutput("rerun_bclk@3", 32'(bclk), 32'd0);
    stepTo(4); checkOutput("rerun_bclk@4", 32'(bclk), 32'd1);
    checkSlot(0, 16'h0000, 1'b0, 1'b0, 1'b0);
    checkSlot(256, 16'h0000, 1'b1, 1'b1, 1'b1);
    checkSlot(512, 16'h0000, 1'b1, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
